// File: rtl/fifo_stream_adapter_if.sv
// rtl/fifo_stream_adapter_if.sv - FIFO read port plus valid/ready stream bundle for fifo_stream_adapter
interface fifo_stream_adapter_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  fifo_rd_en;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;

    // Adapter side: reads the FIFO, drives the stream.
    modport master (
        input  fifo_empty,
        input  fifo_dout,
        output fifo_rd_en,
        output m_valid,
        input  m_ready,
        output m_data
    );

    // Environment side: the FIFO and the stream consumer.
    modport slave (
        output fifo_empty,
        output fifo_dout,
        input  fifo_rd_en,
        input  m_valid,
        output m_ready,
        input  m_data
    );
endinterface

// File: rtl/fifo_stream_adapter.sv
// rtl/fifo_stream_adapter.sv - drains a 1-cycle-latency FIFO into a valid/ready stream via a 2-entry buffer
// Optional accepted-beat counter enabled by defining FIFO_ADPT_BEAT_CNT_EN.
module fifo_stream_adapter #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
`ifdef FIFO_ADPT_BEAT_CNT_EN
    output logic [CNT_WIDTH-1:0] beat_cnt,
`endif
    fifo_stream_adapter_if.master bus
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] head_nxt;
    logic [DATA_WIDTH-1:0] skid;
    logic [DATA_WIDTH-1:0] skid_nxt;
    logic                  inflight;
    logic                  inflight_nxt;

    logic [1:0]            occ;
    logic [1:0]            fill;
    logic                  pop;
    logic                  capture;
    logic                  rd_en;

    assign occ  = state;
    assign fill = occ + {1'b0, inflight};
    assign pop  = bus.m_valid & bus.m_ready;

    // A word already in flight during flush is dropped instead of captured.
    assign capture = inflight & ~flush;

    // Read only if buffer + in-flight word leaves room, counting this cycle's pop.
    assign rd_en = ~rst & ~flush & ~bus.fifo_empty &
                   ((fill <= 2'd1) | ((fill == 2'd2) & pop));

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = (state != ST_EMPTY);
    assign bus.m_data     = head;

    always_comb begin
        state_nxt    = state;
        head_nxt     = head;
        skid_nxt     = skid;
        inflight_nxt = rd_en;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (capture) begin
                        state_nxt = ST_ONE;
                        head_nxt  = bus.fifo_dout;
                    end
                end
                ST_ONE: begin
                    if (capture && pop) begin
                        head_nxt = bus.fifo_dout;
                    end else if (capture) begin
                        state_nxt = ST_TWO;
                        skid_nxt  = bus.fifo_dout;
                    end else if (pop) begin
                        state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        head_nxt = skid;
                        if (capture) begin
                            skid_nxt = bus.fifo_dout;
                        end else begin
                            state_nxt = ST_ONE;
                        end
                    end
                end
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_EMPTY;
            head     <= '0;
            skid     <= '0;
            inflight <= 1'b0;
        end else begin
            state    <= state_nxt;
            head     <= head_nxt;
            skid     <= skid_nxt;
            inflight <= inflight_nxt;
        end
    end

`ifdef FIFO_ADPT_BEAT_CNT_EN
    // Counts every accepted beat, including one popped during flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (pop) begin
            beat_cnt <= beat_cnt + CNT_WIDTH'(1);
        end
    end
`else
    if (CNT_WIDTH < 1) begin : g_cnt_width_unused
    end
`endif

`ifndef SYNTHESIS
    // The read gating must never let a word arrive while both entries are held.
    assert property (@(posedge clk) disable iff (rst)
        !((state == ST_TWO) && capture && !pop));
`endif

endmodule

// File: tb/tb_fifo_stream_adapter.sv
// tb/tb_fifo_stream_adapter.sv - table-driven bench for fifo_stream_adapter with a behavioural FIFO model
module tb_fifo_stream_adapter;
    localparam int DW = 8;
    localparam int CW = 4;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic flush = 1'b0;
`ifdef FIFO_ADPT_BEAT_CNT_EN
    logic [CW-1:0] beat_cnt;
`endif

    fifo_stream_adapter_if #(.DATA_WIDTH(DW)) bus ();

    fifo_stream_adapter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
`ifdef FIFO_ADPT_BEAT_CNT_EN
        .beat_cnt (beat_cnt),
`endif
        .bus      (bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] fifo_q[$];
    int            fifo_n = 0;
    assign bus.fifo_empty = (fifo_n == 0);

    always @(posedge clk) begin
        if (bus.fifo_rd_en && fifo_n > 0) begin
            bus.fifo_dout <= fifo_q.pop_front();
            fifo_n = fifo_n - 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic push_words(input int n, input int base);
        for (int k = 0; k < n; k++) begin
            fifo_q.push_back(DW'(base + k));
            fifo_n = fifo_n + 1;
        end
    endtask

    typedef struct {
        int   push_n;
        int   push_base;
        bit   m_ready;
        bit   flush;
        bit   exp_rd;
        bit   exp_valid;
        int   exp_data;
        int   exp_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input int n, input int base, input bit r, input bit f,
                                input bit rd, input bit v, input int d, input int cnt);
        vec_t x;
        x.push_n = n; x.push_base = base; x.m_ready = r; x.flush = f;
        x.exp_rd = rd; x.exp_valid = v; x.exp_data = d; x.exp_cnt = cnt;
        vecs.push_back(x);
    endfunction

    initial begin
        // Single word 0xA5: read c1, beat c3, gone c4.
        add(1, 'hA5, 1, 0, 1, 0, 0,     0);
        add(0, 0,    1, 0, 0, 0, 0,    -1);
        add(0, 0,    1, 0, 0, 1, 'hA5, -1);
        add(0, 0,    1, 0, 0, 0, 0,     1);
        // Streaming 0..15: word k appears in cycle k+3, reads in cycles 1..16.
        for (int c = 1; c <= 19; c++) begin
            add((c == 1) ? 16 : 0, 0, 1, 0, (c <= 16), (c >= 3 && c <= 18),
                (c >= 3 && c <= 18) ? c - 3 : 0, -1);
        end
        // Backpressure: m_ready low c1..c5, buffer fills to two, then drains in order.
        add(4, 10, 0, 0, 1, 0, 0,  1);
        add(0, 0,  0, 0, 1, 0, 0, -1);
        add(0, 0,  0, 0, 0, 1, 10, -1);
        add(0, 0,  0, 0, 0, 1, 10, -1);
        add(0, 0,  0, 0, 0, 1, 10, -1);
        add(0, 0,  1, 0, 1, 1, 10, -1);
        add(0, 0,  1, 0, 1, 1, 11, -1);
        add(0, 0,  1, 0, 0, 1, 12, -1);
        add(0, 0,  1, 0, 0, 1, 13, -1);
        add(0, 0,  1, 0, 0, 0, 0,   5);
        // Flush with one buffered word and one in flight: 21 is never delivered.
        add(5, 20, 0, 0, 1, 0, 0, -1);
        add(0, 0,  0, 0, 1, 0, 0, -1);
        add(0, 0,  0, 1, 0, 1, 20, 5);
        add(0, 0,  0, 0, 1, 0, 0,  5);
        add(0, 0,  1, 0, 1, 0, 0, -1);
        add(0, 0,  1, 0, 1, 1, 22, -1);
        add(0, 0,  1, 0, 0, 1, 23, -1);
        add(0, 0,  1, 0, 0, 1, 24, -1);
        add(0, 0,  1, 0, 0, 0, 0,   8);
        // Flush with two buffered words while popping: the pop still counts.
        add(3, 30, 0, 0, 1, 0, 0, -1);
        add(0, 0,  0, 0, 1, 0, 0, -1);
        add(0, 0,  0, 0, 0, 1, 30, -1);
        add(0, 0,  0, 0, 0, 1, 30, -1);
        add(0, 0,  1, 1, 0, 1, 30, 8);
        add(0, 0,  1, 0, 1, 0, 0,  9);
        add(0, 0,  1, 0, 0, 0, 0, -1);
        add(0, 0,  1, 0, 0, 1, 32, -1);
        add(0, 0,  1, 0, 0, 0, 0,  10);

        bus.m_ready   = 1'b0;
        bus.fifo_dout = '0;

        // Reset with a full FIFO.
        push_words(16, 'h50);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset_rd_en", int'(bus.fifo_rd_en), 0);
        check("reset_m_valid", int'(bus.m_valid), 0);
        check("reset_m_data", int'(bus.m_data), 0);
`ifdef FIFO_ADPT_BEAT_CNT_EN
        check("reset_beat_cnt", int'(beat_cnt), 0);
`endif
        fifo_q.delete();
        fifo_n = 0;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            push_words(vecs[i].push_n, vecs[i].push_base);
            bus.m_ready = vecs[i].m_ready;
            flush       = vecs[i].flush;
            #1;
            check($sformatf("v%0d_rd_en", i), int'(bus.fifo_rd_en), int'(vecs[i].exp_rd));
            check($sformatf("v%0d_m_valid", i), int'(bus.m_valid), int'(vecs[i].exp_valid));
            if (vecs[i].exp_valid)
                check($sformatf("v%0d_m_data", i), int'(bus.m_data), vecs[i].exp_data);
`ifdef FIFO_ADPT_BEAT_CNT_EN
            if (vecs[i].exp_cnt >= 0)
                check($sformatf("v%0d_beat_cnt", i), int'(beat_cnt), vecs[i].exp_cnt);
`endif
        end

        // Asynchronous reset between edges with a full buffer.
        @(negedge clk);
        flush = 1'b0;
        bus.m_ready = 1'b0;
        push_words(3, 40);
        repeat (3) @(negedge clk);
        #1;
        check("pre_async_m_valid", int'(bus.m_valid), 1);
        check("pre_async_m_data", int'(bus.m_data), 40);
        #2;
        rst = 1'b1;
        #1;
        check("async_rd_en", int'(bus.fifo_rd_en), 0);
        check("async_m_valid", int'(bus.m_valid), 0);
        check("async_m_data", int'(bus.m_data), 0);
`ifdef FIFO_ADPT_BEAT_CNT_EN
        check("async_beat_cnt", int'(beat_cnt), 0);
`endif
        fifo_q.delete();
        fifo_n = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
